// File: rtl/xbus_link_trainer.sv
// ---------------------------------------------------------------------------
// xbus_link_trainer
//   Link-training controller for one xbus receive/transmit lane pair. The
//   local transmitter sends sync symbols while the receiver counts
//   consecutive received syncs. Once LOCK_CNT syncs arrive in a row, the
//   receiver has local lock. Sync is then held for HOLD_CYC cycles so the
//   far end can lock too, and after that the link is declared up. While up,
//   LOSS_CNT consecutive symbol errors drop the link back to training.
//   Training that runs past TIMEOUT cycles is retried. The MAX_RETRY-th
//   timeout parks the controller in FAIL until en_i is deasserted.
//
// Ports
//   clk_i        in   clock, rising edge
//   rst_ni       in   asynchronous active-low reset
//   en_i         in   training enable; low forces IDLE and clears everything
//   sync_i       in   received symbol this cycle is sync
//   valid_i      in   received symbol this cycle is a valid non-sync symbol
//   err_i        in   received symbol this cycle has a code/disparity error
//   tx_sync_o    out  transmitter sends sync symbols (TRAIN or HOLD)
//   training_o   out  state is TRAIN or HOLD
//   link_up_o    out  state is UP
//   fail_o       out  state is FAIL
//   retry_cnt_o  out  timeouts since the last entry to IDLE or UP
//   state_o      out  IDLE=0, TRAIN=1, HOLD=2, UP=3, FAIL=4
// ---------------------------------------------------------------------------
module xbus_link_trainer #(
  parameter int LOCK_CNT  = 8,
  parameter int HOLD_CYC  = 16,
  parameter int TIMEOUT   = 1024,
  parameter int LOSS_CNT  = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       sync_i,
  input  logic       valid_i,
  input  logic       err_i,
  output logic       tx_sync_o,
  output logic       training_o,
  output logic       link_up_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int SYNC_W  = $clog2(LOCK_CNT + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYC + 1);
  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int ERR_W   = $clog2(LOSS_CNT + 1);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  // Terminal values, sized to their counters so the compares are width-clean.
  localparam logic [SYNC_W-1:0]  SYNC_LAST  = SYNC_W'(LOCK_CNT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
  localparam logic [ERR_W-1:0]   ERR_LAST   = ERR_W'(LOSS_CNT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TRAIN = 3'd1,
    ST_HOLD  = 3'd2,
    ST_UP    = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  state_t             r_state;
  logic [SYNC_W-1:0]  r_sync_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [TIMER_W-1:0] r_timer;
  logic [ERR_W-1:0]   r_err_cnt;
  logic [RETRY_W-1:0] r_retry;

  logic               w_lock;
  logic               w_timeout;
  logic [RETRY_W-1:0] w_retry_inc;

  // Lock needs this edge's sync sample on top of LOCK_CNT-1 already counted.
  assign w_lock      = sync_i && (r_sync_cnt == SYNC_LAST);
  assign w_timeout   = (r_timer == TIMER_LAST);
  assign w_retry_inc = r_retry + 1'b1;

  // NOTE: every flop here, counters included, is cleared by the async reset
  // and updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= '0;
      r_hold_cnt <= '0;
      r_timer    <= '0;
      r_err_cnt  <= '0;
      r_retry    <= '0;
    end else if (!en_i) begin
      r_state    <= ST_IDLE;
      r_sync_cnt <= '0;
      r_hold_cnt <= '0;
      r_timer    <= '0;
      r_err_cnt  <= '0;
      r_retry    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_TRAIN;
          r_sync_cnt <= '0;
          r_timer    <= '0;
        end

        ST_TRAIN: begin
          if (w_lock) begin
            // Lock wins over a timeout on the same edge; retry is untouched.
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
          end else if (w_timeout) begin
            r_retry <= w_retry_inc;
            if (w_retry_inc == RETRY_MAX) begin
              r_state <= ST_FAIL;
            end else begin
              r_timer    <= '0;
              r_sync_cnt <= '0;
            end
          end else begin
            r_timer    <= r_timer + 1'b1;
            r_sync_cnt <= sync_i ? r_sync_cnt + 1'b1 : '0;
          end
        end

        ST_HOLD: begin
          if (err_i) begin
            // An error while the far end is still locking restarts training.
            r_state    <= ST_TRAIN;
            r_sync_cnt <= '0;
            r_timer    <= '0;
          end else if (r_hold_cnt == HOLD_LAST) begin
            r_state   <= ST_UP;
            r_retry   <= '0;
            r_err_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        ST_UP: begin
          if (err_i) begin
            if (r_err_cnt == ERR_LAST) begin
              r_state    <= ST_TRAIN;
              r_sync_cnt <= '0;
              r_timer    <= '0;
              r_err_cnt  <= '0;
            end else begin
              r_err_cnt <= r_err_cnt + 1'b1;
            end
          end else if (valid_i || sync_i) begin
            // A clean symbol breaks the error run; idle cycles leave it alone.
            r_err_cnt <= '0;
          end
        end

        ST_FAIL: begin
          // Sticky until en_i drops.
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tx_sync_o   = (r_state == ST_TRAIN) || (r_state == ST_HOLD);
  assign training_o  = (r_state == ST_TRAIN) || (r_state == ST_HOLD);
  assign link_up_o   = (r_state == ST_UP);
  assign fail_o      = (r_state == ST_FAIL);
  assign retry_cnt_o = 4'(r_retry);
  assign state_o     = r_state;

endmodule

// File: doc/xbus_link_trainer.md
Name: xbus_link_trainer

Overview:
- Link-training controller for one xbus receive/transmit lane pair.
- Forces the local transmitter to send sync symbols and counts consecutive received syncs to declare lock.
- Holds sync long enough for the far end to lock, then declares the link up.
- Watches for loss of lock, retrains on timeout or loss, and gives up after a bounded number of retries. Its status feeds the xbus SoC bridge.

Parameters:
- LOCK_CNT, 8: consecutive received sync cycles needed to declare local lock.
- HOLD_CYC, 16: cycles sync keeps transmitting after local lock, before link up.
- TIMEOUT, 1024: cycles allowed in TRAIN before a retry.
- LOSS_CNT, 4: consecutive err_i cycles in UP that drop the link.
- MAX_RETRY, 3: timeouts tolerated; the MAX_RETRY-th timeout enters FAIL.

Ports:
- clk_i  in  1  clock; every flop is rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  training enable; low forces IDLE.
- sync_i  in  1  received symbol this cycle is sync.
- valid_i  in  1  received symbol this cycle is a valid non-sync symbol.
- err_i  in  1  received symbol this cycle has a code or disparity error.
- tx_sync_o  out  1  transmitter sends sync symbols.
- training_o  out  1  state is TRAIN or HOLD.
- link_up_o  out  1  state is UP.
- fail_o  out  1  state is FAIL.
- retry_cnt_o  out  4  timeouts since the last entry to IDLE or UP.
- state_o  out  3  encoding: IDLE=0, TRAIN=1, HOLD=2, UP=3, FAIL=4.

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- Reset (rst_ni low): state IDLE; all counters 0; all outputs 0. Takes effect immediately; release is sampled at clk_i.
- Outputs are Moore decodes of the registered state, except retry_cnt_o, which is a register.
  - tx_sync_o = TRAIN or HOLD.
  - training_o = TRAIN or HOLD.
  - link_up_o = UP.
  - fail_o = FAIL.
- Internal counters: synccnt, holdcnt, timer, errcnt, retry. Each is sized to hold its parameter, using clog2 of (param+1).
- en_i low at any edge → IDLE. Highest priority. All counters including retry clear.
- IDLE: en_i high → TRAIN; clear synccnt and timer.
- TRAIN:
  - sync_i=1: synccnt++. sync_i=0: synccnt←0.
  - Lock: the edge where sync_i=1 and synccnt==LOCK_CNT-1 → HOLD, holdcnt←0. This requires exactly LOCK_CNT consecutive sync samples.
  - Timer increments every TRAIN cycle.
  - Timeout: the edge where timer==TIMEOUT-1 and lock is not taken that edge → retry++.
    - If the new retry value == MAX_RETRY → FAIL.
    - Otherwise stay in TRAIN with timer←0 and synccnt←0.
  - Lock and timeout on the same edge: lock wins, retry unchanged.
- HOLD:
  - holdcnt increments each cycle; the edge where holdcnt==HOLD_CYC-1 → UP. HOLD lasts exactly HOLD_CYC cycles.
  - err_i=1 in HOLD → TRAIN, synccnt←0, timer←0, retry unchanged. err_i takes priority over hold completion on the same edge.
  - sync_i is ignored in HOLD.
- UP:
  - retry←0 on entry.
  - err_i=1: errcnt++. A cycle with err_i=0 and (valid_i or sync_i) clears errcnt. An idle cycle (all three low) holds errcnt.
  - The edge where err_i=1 and errcnt==LOSS_CNT-1 → TRAIN, with synccnt, timer and errcnt cleared.
  - err_i together with valid_i or sync_i counts as an error.
- FAIL: sticky until en_i goes low. tx_sync_o=0.
- Counters never wrap.
  - synccnt cannot exceed LOCK_CNT-1 in TRAIN.
  - retry saturates at MAX_RETRY, reached only in FAIL.
- retry_cnt_o is the zero-extended retry, or truncated if retry is wider than 4 bits.
- sync_i, valid_i and err_i are assumed synchronous to clk_i. No internal synchronizers.

Test Plan:
- Normal bring-up, defaults. Reset, en_i=1 at edge E0, sync_i=1 continuously → expected:
  - state TRAIN after E0, tx_sync_o=1.
  - HOLD after E8.
  - UP after E24: link_up_o=1, tx_sync_o=0, retry_cnt_o=0.
- Broken sync run. In TRAIN, 7 syncs, one non-sync cycle, then 8 syncs → HOLD only after the second run's 8th sync. State stays TRAIN in between.
- Timeouts. en_i=1, sync_i=0 forever → expected:
  - retry_cnt_o=1 after 1024 TRAIN cycles, 2 after 2048.
  - FAIL after 3072 cycles: fail_o=1, tx_sync_o=0.
  - Then en_i=0 → IDLE next edge, retry_cnt_o=0.
- Lock/timeout collision. Lock condition met on the edge where timer==1023 → HOLD, retry_cnt_o unchanged.
- Loss in UP.
  - err_i pattern 1,1,1,0(valid),1,1,1 → stays UP.
  - Then a 4th consecutive err_i → TRAIN on that edge, tx_sync_o=1.
  - err_i during HOLD → TRAIN.
- Async reset mid-operation. rst_ni low while UP, between clock edges → state_o=0 and all outputs 0 before the next edge. Release with en_i=1 → TRAIN on the first edge.
